// File: rtl/wb_uart_arbiter.sv
// Two-master round-robin Wishbone classic arbiter in front of wbuart.
// Grant is held for the whole bus cycle; a stuck slave is aborted after TIMEOUT wait cycles.
module wb_uart_arbiter #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TW      = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_m0_cyc,
  input  logic          i_m0_stb,
  input  logic          i_m0_we,
  input  logic [3:0]    i_m0_sel,
  input  logic [1:0]    i_m0_addr,
  input  logic [31:0]   i_m0_data,
  output logic          o_m0_ack,
  output logic          o_m0_err,
  output logic [31:0]   o_m0_data,
  input  logic          i_m1_cyc,
  input  logic          i_m1_stb,
  input  logic          i_m1_we,
  input  logic [3:0]    i_m1_sel,
  input  logic [1:0]    i_m1_addr,
  input  logic [31:0]   i_m1_data,
  output logic          o_m1_ack,
  output logic          o_m1_err,
  output logic [31:0]   o_m1_data,
  output logic          o_s_cyc,
  output logic          o_s_stb,
  output logic          o_s_we,
  output logic [3:0]    o_s_sel,
  output logic [1:0]    o_s_addr,
  output logic [31:0]   o_s_data,
  input  logic          i_s_ack,
  input  logic [31:0]   i_s_data,
  output logic [1:0]    o_grant,
  output logic [TW-1:0] o_timeout_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_OWN0, S_OWN1, S_DRAIN0, S_DRAIN1} state_t;

  localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          err0_q, err0_d;
  logic          err1_q, err1_d;
  logic          own0, own1, own_cyc;

  assign own0    = (state_q == S_OWN0);
  assign own1    = (state_q == S_OWN1);
  assign own_cyc = own0 ? i_m0_cyc : i_m1_cyc;

  // Slave side follows the owner combinationally so a dropped cyc reaches wbuart in the same cycle.
  always_comb begin
    o_s_cyc  = 1'b0;
    o_s_stb  = 1'b0;
    o_s_we   = 1'b0;
    o_s_sel  = '0;
    o_s_addr = '0;
    o_s_data = '0;
    if (own0) begin
      o_s_cyc  = i_m0_cyc;
      o_s_stb  = i_m0_stb;
      o_s_we   = i_m0_we;
      o_s_sel  = i_m0_sel;
      o_s_addr = i_m0_addr;
      o_s_data = i_m0_data;
    end else if (own1) begin
      o_s_cyc  = i_m1_cyc;
      o_s_stb  = i_m1_stb;
      o_s_we   = i_m1_we;
      o_s_sel  = i_m1_sel;
      o_s_addr = i_m1_addr;
      o_s_data = i_m1_data;
    end
  end

  assign o_m0_ack      = own0 & i_s_ack;
  assign o_m1_ack      = own1 & i_s_ack;
  assign o_m0_data     = own0 ? i_s_data : '0;
  assign o_m1_data     = own1 ? i_s_data : '0;
  assign o_m0_err      = err0_q;
  assign o_m1_err      = err1_q;
  assign o_grant       = {(state_q == S_OWN1) || (state_q == S_DRAIN1),
                          (state_q == S_OWN0) || (state_q == S_DRAIN0)};
  assign o_timeout_cnt = cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    last_d  = last_q;
    err0_d  = 1'b0;
    err1_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_m0_cyc && (!i_m1_cyc || last_q)) begin
          state_d = S_OWN0;
          last_d  = 1'b0;
        end else if (i_m1_cyc) begin
          state_d = S_OWN1;
          last_d  = 1'b1;
        end
      end
      S_OWN0, S_OWN1: begin
        if (!own_cyc) begin
          state_d = S_IDLE;
        end else if (o_s_stb && !i_s_ack) begin
          if (cnt_q >= TMO) begin
            state_d = own0 ? S_DRAIN0 : S_DRAIN1;
            err0_d  = own0;
            err1_d  = own1;
          end else begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + TW'(1);
          end
        end
      end
      S_DRAIN0: if (!i_m0_cyc) state_d = S_IDLE;
      S_DRAIN1: if (!i_m1_cyc) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
    end
  end

endmodule

// File: tb/tb_wb_uart_arbiter.sv
// Randomized scoreboard bench for wb_uart_arbiter: masters queue their expected outcome,
// a negedge monitor checks bus routing every cycle and pops the queue on each ack/err.
module tb_wb_uart_arbiter;

  localparam int unsigned TMO = 8;
  localparam int unsigned TW  = 16;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [7:0]  delay;   // stb cycle index on which the slave acks
    logic [31:0] rdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_cyc [2];
  logic        m_stb [2];
  logic        m_we  [2];
  logic [3:0]  m_sel [2];
  logic [1:0]  m_addr[2];
  logic [31:0] m_wdat[2];
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdat, m1_rdat;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [1:0]  s_addr;
  logic [31:0] s_wdat;
  logic        s_ack;
  logic [31:0] s_rdat;
  logic [1:0]  grant;
  logic [TW-1:0] tcnt;

  int errors = 0;
  int checks = 0;

  txn_t q0[$];
  txn_t q1[$];

  // Reference view of the arbiter: who holds the bus and how long the slave has stalled.
  bit          mdl_have, mdl_own, mdl_drain, mdl_first;
  bit          mdl_last = 1'b1;
  int unsigned mdl_cnt = 0;
  int unsigned mdl_start = 0;
  int unsigned cyc_n = 0;

  wb_uart_arbiter #(.TIMEOUT(TMO), .TW(TW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m0_cyc(m_cyc[0]), .i_m0_stb(m_stb[0]), .i_m0_we(m_we[0]),
    .i_m0_sel(m_sel[0]), .i_m0_addr(m_addr[0]), .i_m0_data(m_wdat[0]),
    .o_m0_ack(m0_ack), .o_m0_err(m0_err), .o_m0_data(m0_rdat),
    .i_m1_cyc(m_cyc[1]), .i_m1_stb(m_stb[1]), .i_m1_we(m_we[1]),
    .i_m1_sel(m_sel[1]), .i_m1_addr(m_addr[1]), .i_m1_data(m_wdat[1]),
    .o_m1_ack(m1_ack), .o_m1_err(m1_err), .o_m1_data(m1_rdat),
    .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we), .o_s_sel(s_sel),
    .o_s_addr(s_addr), .o_s_data(s_wdat), .i_s_ack(s_ack), .i_s_data(s_rdat),
    .o_grant(grant), .o_timeout_cnt(tcnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc_n, act, exp);
    end
  endfunction

  function automatic txn_t mk(input logic we, input logic [3:0] sel, input logic [1:0] addr,
                              input logic [31:0] data, input logic [7:0] delay);
    txn_t t;
    t.we = we; t.sel = sel; t.addr = addr; t.data = data; t.delay = delay;
    t.rdata = $urandom;
    return t;
  endfunction

  function automatic txn_t rnd_txn();
    return mk(1'($urandom), 4'($urandom), 2'($urandom), $urandom, 8'($urandom_range(0, TMO + 2)));
  endfunction

  task automatic issue(input int idx, input txn_t t);
    int unsigned n;
    bit got;
    @(posedge clk); #1;
    if (idx == 0) q0.push_back(t); else q1.push_back(t);
    m_cyc[idx] = 1'b1; m_stb[idx] = 1'b1; m_we[idx] = t.we;
    m_sel[idx] = t.sel; m_addr[idx] = t.addr; m_wdat[idx] = t.data;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      got = (idx == 0) ? (m0_ack | m0_err) : (m1_ack | m1_err);
    end while (!got && n < 200);
    if (!got) begin
      checks++; errors++;
      $display("FAIL m%0d_resp: no ack or err within 200 cycles", idx);
    end
    @(posedge clk); #1;
    m_cyc[idx] = 1'b0; m_stb[idx] = 1'b0;
  endtask

  // Slave: acks the owner's beat on its chosen stb cycle; strays an ack now and then when nobody may see it.
  initial begin
    txn_t t;
    int unsigned swait;
    s_ack = 1'b0; s_rdat = '0; swait = 0;
    forever begin
      @(posedge clk); #2;
      s_ack = 1'b0;
      if (s_stb && mdl_have && !mdl_drain && ((mdl_own ? q1.size() : q0.size()) != 0)) begin
        t = mdl_own ? q1[0] : q0[0];
        if (swait == 32'(t.delay)) begin
          s_ack = 1'b1; s_rdat = t.rdata; swait = 0;
        end else begin
          swait++;
        end
      end else begin
        swait = 0;
        if ((!mdl_have || mdl_drain) && $urandom_range(0, 5) == 0) begin
          s_ack = 1'b1; s_rdat = $urandom;
        end
      end
    end
  end

  always @(negedge clk) begin
    txn_t t;
    bit live, ack_v, err_v;
    logic [31:0] dat_v;
    if (!rst_n) begin
      mdl_have = 1'b0; mdl_drain = 1'b0; mdl_first = 1'b0; mdl_last = 1'b1; mdl_cnt = 0;
      q0.delete(); q1.delete();
    end else begin
      live = mdl_have && !mdl_drain;
      chk("grant", grant, mdl_have ? (mdl_own ? 2'b10 : 2'b01) : 2'b00);
      chk("s_cyc", s_cyc, live && m_cyc[mdl_own]);
      chk("s_stb", s_stb, live && m_stb[mdl_own]);
      chk("s_fields", {s_we, s_sel, s_addr, s_wdat},
          live ? {m_we[mdl_own], m_sel[mdl_own], m_addr[mdl_own], m_wdat[mdl_own]} : 39'h0);
      chk("timeout_cnt", tcnt, mdl_cnt);
      for (int x = 0; x < 2; x++) begin
        ack_v = (x == 0) ? m0_ack : m1_ack;
        err_v = (x == 0) ? m0_err : m1_err;
        dat_v = (x == 0) ? m0_rdat : m1_rdat;
        chk($sformatf("m%0d_ack", x), ack_v, live && (mdl_own == x[0]) && s_ack);
        chk($sformatf("m%0d_data", x), dat_v, (live && (mdl_own == x[0])) ? s_rdat : 32'h0);
        chk($sformatf("m%0d_err", x), err_v, mdl_drain && mdl_first && (mdl_own == x[0]));
        if (ack_v || err_v) begin
          if (((x == 0) ? q0.size() : q1.size()) == 0) begin
            checks++; errors++;
            $display("FAIL m%0d_sb: response with no outstanding transaction, got ack=%0b err=%0b, expected none", x, ack_v, err_v);
          end else begin
            if (x == 0) t = q0.pop_front(); else t = q1.pop_front();
            chk($sformatf("m%0d_resp_kind", x), {err_v, ack_v}, (32'(t.delay) > TMO) ? 2'b10 : 2'b01);
            if (ack_v) begin
              chk($sformatf("m%0d_rdata", x), dat_v, t.rdata);
              chk($sformatf("m%0d_beat", x), {s_we, s_sel, s_addr, s_wdat}, {t.we, t.sel, t.addr, t.data});
            end else begin
              chk($sformatf("m%0d_err_cycle", x), cyc_n, mdl_start + TMO + 1);
            end
          end
        end
      end
      if (!mdl_have) begin
        mdl_cnt = 0;
        if (m_cyc[0] && (!m_cyc[1] || mdl_last)) begin
          mdl_have = 1'b1; mdl_own = 1'b0; mdl_last = 1'b0; mdl_start = cyc_n + 1;
        end else if (m_cyc[1]) begin
          mdl_have = 1'b1; mdl_own = 1'b1; mdl_last = 1'b1; mdl_start = cyc_n + 1;
        end
      end else if (mdl_drain) begin
        mdl_first = 1'b0;
        if (!m_cyc[mdl_own]) begin mdl_have = 1'b0; mdl_drain = 1'b0; end
      end else if (!m_cyc[mdl_own]) begin
        mdl_have = 1'b0; mdl_cnt = 0;
      end else if (m_stb[mdl_own] && !s_ack) begin
        if (mdl_cnt >= TMO) begin
          mdl_drain = 1'b1; mdl_first = 1'b1; mdl_cnt = 0;
        end else begin
          mdl_cnt++;
        end
      end else begin
        mdl_cnt = 0;
      end
    end
    cyc_n++;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_cyc[i] = 1'b1; m_stb[i] = 1'b1; m_we[i] = 1'b1;
      m_sel[i] = 4'hF; m_addr[i] = 2'd3; m_wdat[i] = $urandom;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_slave", {s_cyc, s_stb, s_we, s_sel, s_addr, s_wdat}, 41'h0);
    chk("rst_m0", {m0_ack, m0_err, m0_rdat}, 34'h0);
    chk("rst_m1", {m1_ack, m1_err, m1_rdat}, 34'h0);
    chk("rst_cnt", tcnt, 0);
    for (int i = 0; i < 2; i++) begin m_cyc[i] = 1'b0; m_stb[i] = 1'b0; end
    #2 rst_n = 1'b1;

    // Contested start twice: m0, m1, then m0 again on the second round.
    for (int r = 0; r < 2; r++) begin
      fork
        issue(0, mk(1'b1, 4'hF, 2'd1, 32'h1111_0000 + 32'(r), 8'd1));
        issue(1, mk(1'b1, 4'hF, 2'd2, 32'h2222_0000 + 32'(r), 8'd0));
      join
    end

    issue(0, mk(1'b1, 4'hF, 2'd0, 32'd434, 8'd2));

    // m1 owns while m0 arrives mid-transfer.
    fork
      issue(1, mk(1'b1, 4'h1, 2'd3, 32'h47, 8'd6));
      begin repeat (2) @(posedge clk); issue(0, mk(1'b0, 4'hF, 2'd2, 32'h0, 8'd1)); end
    join

    issue(0, mk(1'b1, 4'hF, 2'd0, 32'hDEAD_BEEF, 8'd20));
    issue(0, mk(1'b1, 4'hF, 2'd1, 32'hA5A5_0008, 8'(TMO)));
    issue(1, mk(1'b0, 4'h3, 2'd2, 32'h0, 8'(TMO + 1)));

    fork
      for (int k = 0; k < 50; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        issue(0, rnd_txn());
      end
      for (int j = 0; j < 50; j++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        issue(1, rnd_txn());
      end
    join

    // Asynchronous reset while m1 holds the bus with stb high.
    @(posedge clk); #1;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
    m_sel[1] = 4'h1; m_addr[1] = 2'd3; m_wdat[1] = 32'h47;
    repeat (3) @(posedge clk);
    #3;
    chk("pre_arst_grant", grant, 2'b10);
    chk("pre_arst_stb", s_stb, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_s_cyc", s_cyc, 1'b0);
    chk("arst_s_stb", s_stb, 1'b0);
    chk("arst_grant", grant, 2'b00);
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin m_cyc[i] = 1'b1; m_stb[i] = 1'b1; end
    repeat (2) @(negedge clk);
    chk("post_arst_winner", grant, 2'b01);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin m_cyc[i] = 1'b0; m_stb[i] = 1'b0; end
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
